sorting_feeder: RTL

Store-and-forward packet stage directly upstream of the sorting wrapper. Captures sop/eop/val-framed packets into two ping-pong banks of 2**AWIDTH words each. Releases each complete packet as one contiguous burst only when the sorter reports not busy. Drops packets that cannot be buffered or that are malformed, so the sorter only ever sees well-formed packets of legal length.

---
 rtl/sorting_feeder.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sorting_feeder.sv
// Store-and-forward feeder: buffers framed packets in two ping-pong banks
// and releases each complete packet as one burst when the sorter is idle.
// Ports: clk_i/arst_n_i clock and async active-low reset;
//   data_i/sop_i/eop_i/val_i upstream packet beats;
//   data_o/sop_o/eop_o/val_o registered burst to sorter;
//   busy_i sorter busy; drop_o one-cycle pulse per discarded packet.
// Optional: define SORTING_FEEDER_STATS_EN to add pkt_cnt_o and drop_cnt_o.
module sorting_feeder #(
  parameter int AWIDTH   = 3,
  parameter int DWIDTH   = 8,
  parameter int BUSY_GAP = 4
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              val_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              val_o,
  input  logic              busy_i,
  output logic              drop_o
`ifdef SORTING_FEEDER_STATS_EN
  ,
  output logic [15:0]       pkt_cnt_o,
  output logic [15:0]       drop_cnt_o
`endif
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int PW    = AWIDTH + 1;
  localparam int GW    = (BUSY_GAP < 2) ? 1 : $clog2(BUSY_GAP + 1);

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DISC} wst_e;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_GAP} rst_e;

  wst_e wst_q, wst_d;
  rst_e rst_q, rst_d;

  logic                   wbank_q, wbank_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [1:0]             full_q, full_d;
  logic [1:0][PW-1:0]     len_q, len_d;
  logic                   head_q, head_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [DWIDTH-1:0]      data_q, data_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic                   val_q, val_d;
  logic                   drop_q, drop_d;

  logic [DWIDTH-1:0]      mem_q [2][DEPTH];

  logic                   emit, last, start, commit, we;
  logic [1:0]             free, fresh, empty;
  logic [PW-1:0]          clen;
  logic [AWIDTH-1:0]      waddr;

  always_comb begin
    rst_d  = rst_q;
    rptr_d = rptr_q;
    gap_d  = gap_q;
    head_d = head_q;
    data_d = data_q;
    sop_d  = 1'b0;
    eop_d  = 1'b0;
    val_d  = 1'b0;
    free   = 2'b00;

    // First word leaves straight from IDLE so eop_i -> val_o is 2 cycles.
    emit = ((rst_q == R_IDLE) && full_q[head_q] && !busy_i) ||
           (rst_q == R_SEND);
    last = (rptr_q == len_q[head_q] - PW'(1));

    if (rst_q == R_GAP) begin
      gap_d = gap_q - GW'(1);
      if (gap_q <= GW'(1)) rst_d = R_IDLE;
    end

    if (emit) begin
      val_d  = 1'b1;
      sop_d  = (rptr_q == '0);
      data_d = mem_q[head_q][rptr_q[AWIDTH-1:0]];
      if (last) begin
        eop_d        = 1'b1;
        free[head_q] = 1'b1;
        rptr_d       = '0;
        gap_d        = GW'(BUSY_GAP);
        rst_d        = (BUSY_GAP == 0) ? R_IDLE : R_GAP;
      end else begin
        rptr_d = rptr_q + PW'(1);
        rst_d  = R_SEND;
      end
    end

    wst_d   = wst_q;
    wbank_d = wbank_q;
    wptr_d  = wptr_q;
    drop_d  = 1'b0;
    we      = 1'b0;
    waddr   = wptr_q[AWIDTH-1:0];
    commit  = 1'b0;
    clen    = PW'(1);
    start   = 1'b0;
    // A bank whose last word is read this cycle is already claimable.
    fresh   = full_q & ~free;
    empty   = ~fresh;

    case (wst_q)
      W_IDLE: begin
        if (val_i && sop_i) start = 1'b1;
      end
      W_RECV: begin
        if (val_i) begin
          if (sop_i) begin
            drop_d = 1'b1;
            we     = 1'b1;
            waddr  = '0;
            if (eop_i) begin
              commit = 1'b1;
              wst_d  = W_IDLE;
            end else begin
              wptr_d = PW'(1);
            end
          end else if (wptr_q == PW'(DEPTH)) begin
            if (eop_i) begin
              drop_d = 1'b1;
              wst_d  = W_IDLE;
            end else begin
              wst_d = W_DISC;
            end
          end else begin
            we = 1'b1;
            if (eop_i) begin
              commit = 1'b1;
              clen   = wptr_q + PW'(1);
              wst_d  = W_IDLE;
            end else begin
              wptr_d = wptr_q + PW'(1);
            end
          end
        end
      end
      W_DISC: begin
        if (val_i) begin
          if (sop_i) begin
            drop_d = 1'b1;
            start  = 1'b1;
          end else if (eop_i) begin
            drop_d = 1'b1;
            wst_d  = W_IDLE;
          end
        end
      end
      default: wst_d = W_IDLE;
    endcase

    if (start) begin
      if (empty != 2'b00) begin
        wbank_d = empty[0] ? 1'b0 : 1'b1;
        we      = 1'b1;
        waddr   = '0;
        if (eop_i) begin
          commit = 1'b1;
          wst_d  = W_IDLE;
        end else begin
          wptr_d = PW'(1);
          wst_d  = W_RECV;
        end
      end else if (eop_i) begin
        drop_d = 1'b1;
        wst_d  = W_IDLE;
      end else begin
        wst_d = W_DISC;
      end
    end

    full_d = fresh;
    len_d  = len_q;
    // With two banks the queue head simply flips when it is released.
    if (free != 2'b00) head_d = ~head_q;
    if (commit) begin
      full_d[wbank_d] = 1'b1;
      len_d[wbank_d]  = clen;
      if (fresh == 2'b00) head_d = wbank_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wbank_d][waddr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wst_q   <= W_IDLE;
      rst_q   <= R_IDLE;
      wbank_q <= 1'b0;
      wptr_q  <= '0;
      full_q  <= '0;
      len_q   <= '0;
      head_q  <= 1'b0;
      rptr_q  <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      wst_q   <= wst_d;
      rst_q   <= rst_d;
      wbank_q <= wbank_d;
      wptr_q  <= wptr_d;
      full_q  <= full_d;
      len_q   <= len_d;
      head_q  <= head_d;
      rptr_q  <= rptr_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      val_q   <= val_d;
      drop_q  <= drop_d;
    end
  end

  assign data_o = data_q;
  assign sop_o  = sop_q;
  assign eop_o  = eop_q;
  assign val_o  = val_q;
  assign drop_o = drop_q;

`ifdef SORTING_FEEDER_STATS_EN
  logic [15:0] pkt_cnt_q, drop_cnt_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (val_q && eop_q && (pkt_cnt_q != 16'hFFFF))
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (drop_q && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
